// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronises rx_i, detects the start edge, samples each bit mid-cell and
// reports good frames with rx_done_o or a low stop bit with frame_err_o.
`timescale 1ns/1ps

module uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_done_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic                 start_edge;

  // Synchroniser and edge history reset to idle-high so reset release never looks like a start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          state_d = rx_s_q ? StIdle : StData;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          // LSB arrives first, so shifting in from the top leaves it at bit 0 after the last bit.
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BitW'(1);
          cnt_d   = '0;
          if (bit_q == LastBit) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (cnt_q == FullCnt) begin
          if (rx_s_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data_o   = data_q;
  assign rx_done_o   = done_q;
  assign frame_err_o = err_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit: good, glitch, bad-stop, back-to-back,
// mid-frame reset and break scenarios.
`timescale 1ns/1ps

module tb_uart_rx_frame;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Nb  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [Nb-1:0] rx_data;
  logic          rx_done;
  logic          frame_err;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_done = 0;

  uart_rx_frame #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (Nb)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_i       (rx),
    .rx_data_o  (rx_data),
    .rx_done_o  (rx_done),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt  <= done_cnt + 1;
      last_done <= cyc;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (rx_done && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [Nb-1:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < Nb; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h done=%b err=%b busy=%b, want 00/0/0/0",
               rx_data, rx_done, frame_err, busy);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%0d err=%0d, want 0/0/0", busy, done_cnt,
               err_cnt);
    end
  endtask

  task automatic test_good_frame;
    int d0, e0, t0, lat;
    d0 = done_cnt;
    e0 = err_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    lat = last_done - t0;
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++;
      $display("FAIL good_pulses: done=%0d err=%0d, want 1/0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL good_data: got %h, want a5", rx_data);
    end
    checks++;
    if (lat < 153 || lat > 155) begin
      errors++;
      $display("FAIL good_latency: got %0d cycles, want 154 +/-1", lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL good_busy_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_high: busy=%b, want 1", busy);
    end
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_abort: done=%0d err=%0d busy=%b, want 0/0/0", done_cnt - d0,
               err_cnt - e0, busy);
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL glitch_data: got %h, want a5", rx_data);
    end
  endtask

  task automatic test_stop_err;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      errors++;
      $display("FAIL stop_err_pulses: err=%0d done=%0d, want 1/0", err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL stop_err_data: got %h, want a5", rx_data);
    end
  endtask

  task automatic test_back_to_back;
    int d0, t1, t2;
    d0 = done_cnt;
    send_frame(8'h00, 1'b1);
    t1 = last_done;
    checks++;
    if (rx_data !== 8'h00 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL b2b_first: data=%h done=%0d, want 00/1", rx_data, done_cnt - d0);
    end
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    t2 = last_done;
    checks++;
    if (rx_data !== 8'hFF || done_cnt - d0 != 2) begin
      errors++;
      $display("FAIL b2b_second: data=%h done=%0d, want ff/2", rx_data, done_cnt - d0);
    end
    checks++;
    if (t2 - t1 < 159 || t2 - t1 > 161) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, want 160 +/-1", t2 - t1);
    end
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    logic [Nb-1:0] d;
    d = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: data=%h done=%b err=%b busy=%b, want 00/0/0/0",
               rx_data, rx_done, frame_err, busy);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (rx_data !== 8'h5A || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++;
      $display("FAIL midreset_recover: data=%h done=%0d err=%0d, want 5a/1/0", rx_data,
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_break;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (300) @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    checks++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL break_err: err=%0d done=%0d busy=%b, want 1/0/0", err_cnt - e0,
               done_cnt - d0, busy);
    end
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (rx_data !== 8'h81 || done_cnt - d0 != 1 || err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL break_recover: data=%h done=%0d err=%0d, want 81/1/1", rx_data,
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL exclusive: done and err together %0d times, want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_reset_mid();
    test_break();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial receive end of the host link: deserialises 8N1 UART frames arriving on the `rx` pin.
- Outputs each received byte with a one-cycle `rx_done` strobe, and flags frames whose stop bit is bad.
- Counterpart to the transmit-trigger path: `rx_done` is the event that downstream command/readout logic reacts to, just as the TX side reacts to `tx_done`.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last correctly framed byte; held until the next good frame.
- rx_done  output  1  one-cycle pulse: `rx_data` just updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress (START/DATA/STOP).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rx_data=0; rx_done=0; frame_err=0; busy=0.
  - Bit and clock counters cleared.
  - Synchroniser flops and edge-history flop set to 1 (idle level), so no false start is seen on reset release.
- Input path:
  - 2-flop synchroniser rx -> rx_s.
  - One further flop rx_q holds the previous rx_s.
  - Start edge = rx_q==1 && rx_s==0.
- Clock counter:
  - Width $clog2(CLKS_PER_BIT).
  - Cleared on every state transition; increments each cycle otherwise.
- IDLE:
  - busy=0.
  - On start edge -> START, counter=0.
  - A line held low (break) produces no new start until rx_s has returned high and fallen again.
- START:
  - At counter == CLKS_PER_BIT/2 - 1, sample rx_s (mid start bit).
  - rx_s==0 -> DATA, bit index=0.
  - rx_s==1 -> glitch; -> IDLE with no output pulse.
- DATA:
  - At counter == CLKS_PER_BIT-1, shift rx_s into the shift register at position bit index (LSB first) and increment bit index.
  - After DATA_BITS samples -> STOP.
- STOP:
  - At counter == CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: rx_data <= shift register; rx_done=1 for exactly one cycle.
  - rx_s==0: frame_err=1 for one cycle; rx_data unchanged.
  - Either case -> IDLE on the next cycle.
  - Because STOP ends at mid stop bit, a back-to-back frame whose start bit follows a single stop bit is caught.
- Output exclusivity: rx_done and frame_err are never high together; each is high for one cycle per frame at most.
- Latency: rx_done rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles (±1) after the falling edge on rx.
- Reset mid-frame: aborts immediately to the reset values above; the partial byte is discarded with no pulse. The next complete frame is received normally.
- Baud tolerance: mid-bit sampling; ±3% cumulative clock mismatch over one frame must still decode correctly.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> rx_data=0xA5, one rx_done pulse about 154 cycles after the edge; frame_err never high; busy falls after the stop sample.
- rx low for 4 cycles, then high -> START aborts at the mid-start sample; no rx_done, no frame_err; busy returns to 0; rx_data unchanged.
- After 0xA5, send 0x3C with stop bit 0 -> one frame_err pulse, no rx_done, rx_data stays 0xA5.
- 0x00 then 0xFF back to back, one stop bit each -> two rx_done pulses, 160 cycles apart (±1); rx_data=0x00 then 0xFF.
- Assert rst during bit 4 of a frame -> all outputs 0 immediately; after release, frame 0x5A -> rx_data=0x5A with one rx_done.
- rx held low for 300 cycles (break), then high for 32 cycles, then frame 0x81 -> exactly one frame_err pulse for the break; then rx_data=0x81 with one rx_done.
